// File: rtl/dmem_pkg.sv
// ============================================================================
// Module   : dmem_pkg
// Purpose  : Shared encodings, FSM state type and alignment helper for the
//            data-memory arbiter.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package dmem_pkg;

   localparam logic [1:0] SIZE_WORD = 2'b00;
   localparam logic [1:0] SIZE_HALF = 2'b01;
   localparam logic [1:0] SIZE_BYTE = 2'b10;

   typedef enum logic [0:0] {
      IDLE   = 1'b0,
      ACCESS = 1'b1
   } state_e;

   // Size 2'b11 has no encoding and is always rejected.
   function automatic logic access_ok(input logic [1:0] size, input logic [1:0] addr_lo);
      logic ok;
      case (size)
         SIZE_WORD: ok = (addr_lo == 2'b00);
         SIZE_HALF: ok = ~addr_lo[0];
         SIZE_BYTE: ok = 1'b1;
         default:   ok = 1'b0;
      endcase
      return ok;
   endfunction

endpackage

`default_nettype wire

// File: rtl/dmem_arbiter_if.sv
// ============================================================================
// Module   : dmem_arbiter_if
// Purpose  : Requester and memory-side bundle of the data-memory arbiter.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface dmem_arbiter_if #(
   parameter int N_PORTS = 2
);

   logic [N_PORTS-1:0]    req;
   logic [N_PORTS-1:0]    req_we;
   logic [2*N_PORTS-1:0]  req_size;
   logic [N_PORTS-1:0]    req_sign;
   logic [32*N_PORTS-1:0] req_addr;
   logic [32*N_PORTS-1:0] req_wdata;
   logic [N_PORTS-1:0]    gnt;
   logic [N_PORTS-1:0]    rvalid;
   logic                  rerr;
   logic [31:0]           rdata;
   logic                  mem_we;
   logic [1:0]            mem_size;
   logic                  mem_sign;
   logic [31:0]           mem_addr;
   logic [31:0]           mem_wdata;
   logic [31:0]           mem_rdata;

   // Arbiter side.
   modport slave (
      input  req, req_we, req_size, req_sign, req_addr, req_wdata, mem_rdata,
      output gnt, rvalid, rerr, rdata, mem_we, mem_size, mem_sign, mem_addr, mem_wdata
   );

   // Requesters plus the memory itself.
   modport master (
      output req, req_we, req_size, req_sign, req_addr, req_wdata, mem_rdata,
      input  gnt, rvalid, rerr, rdata, mem_we, mem_size, mem_sign, mem_addr, mem_wdata
   );

endinterface

`default_nettype wire

// File: rtl/rr_arbiter.sv
// ============================================================================
// Module   : rr_arbiter
// Purpose  : Combinational round-robin pick; search starts at rr_ptr, wraps.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module rr_arbiter #(
   parameter int N  = 2,
   parameter int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] rr_ptr,
   output logic [N-1:0]  gnt,
   output logic [IW-1:0] winner
);

   always_comb begin
      logic found;
      int   idx;
      gnt    = '0;
      winner = '0;
      found  = 1'b0;
      idx    = 0;
      for (int i = 0; i < N; i++) begin
         idx = (int'(rr_ptr) + i) % N;
         if (!found && req[idx]) begin
            found    = 1'b1;
            gnt[idx] = 1'b1;
            winner   = IW'(idx);
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/dmem_arbiter.sv
// ============================================================================
// Module   : dmem_arbiter
// Purpose  : Round-robin sharing of a single-ported data memory, one access
//            in flight, with misaligned/invalid accesses rejected locally.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module dmem_arbiter
   import dmem_pkg::*;
#(
   parameter int N_PORTS     = 2,
   parameter int WAIT_CYCLES = 0
) (
   input  logic          clk,
   input  logic          rst_n,
   dmem_arbiter_if.slave bus
);

   localparam int                  c_idx_w     = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;
   localparam logic [c_idx_w-1:0]  c_last_port = c_idx_w'(N_PORTS - 1);
   localparam logic [3:0]          c_wait_init = 4'(WAIT_CYCLES);

   state_e               state_q,  state_d;
   logic [c_idx_w-1:0]   rr_ptr_q, rr_ptr_d;
   logic [c_idx_w-1:0]   win_q,    win_d;
   logic                 we_q,     we_d;
   logic [1:0]           size_q,   size_d;
   logic                 sign_q,   sign_d;
   logic [31:0]          addr_q,   addr_d;
   logic [31:0]          wdata_q,  wdata_d;
   logic [3:0]           wait_q,   wait_d;
   logic [N_PORTS-1:0]   rvalid_q, rvalid_d;
   logic                 rerr_q,   rerr_d;
   logic [31:0]          rdata_q,  rdata_d;

   logic [N_PORTS-1:0]   w_arb_gnt;
   logic [c_idx_w-1:0]   w_win;
   logic [N_PORTS-1:0]   w_gnt;
   logic                 w_mem_we;
   logic [1:0]           w_sel_size;
   logic [31:0]          w_sel_addr;

   rr_arbiter #(
      .N  (N_PORTS),
      .IW (c_idx_w)
   ) u_rr_arbiter (
      .req    (bus.req),
      .rr_ptr (rr_ptr_q),
      .gnt    (w_arb_gnt),
      .winner (w_win)
   );

   assign w_sel_size = bus.req_size[2*w_win +: 2];
   assign w_sel_addr = bus.req_addr[32*w_win +: 32];

   always_comb begin
      state_d  = state_q;
      rr_ptr_d = rr_ptr_q;
      win_d    = win_q;
      we_d     = we_q;
      size_d   = size_q;
      sign_d   = sign_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      wait_d   = wait_q;
      rvalid_d = '0;
      rerr_d   = rerr_q;
      rdata_d  = rdata_q;
      w_gnt    = '0;
      w_mem_we = 1'b0;

      case (state_q)
         IDLE: begin
            if (|bus.req) begin
               w_gnt    = w_arb_gnt;
               win_d    = w_win;
               rr_ptr_d = (w_win == c_last_port) ? '0 : w_win + 1'b1;
               if (!access_ok(w_sel_size, w_sel_addr[1:0])) begin
                  // Rejected in place: respond next cycle, memory fields untouched.
                  rvalid_d = w_arb_gnt;
                  rerr_d   = 1'b1;
                  rdata_d  = '0;
               end else begin
                  we_d    = bus.req_we[w_win];
                  size_d  = w_sel_size;
                  sign_d  = bus.req_sign[w_win];
                  addr_d  = w_sel_addr;
                  wdata_d = bus.req_wdata[32*w_win +: 32];
                  wait_d  = c_wait_init;
                  state_d = ACCESS;
               end
            end
         end

         ACCESS: begin
            // Write strobe only on the final cycle gives exactly one write edge.
            w_mem_we = we_q && (wait_q == 4'd0);
            if (wait_q != 4'd0) begin
               wait_d = wait_q - 4'd1;
            end else begin
               rvalid_d        = '0;
               rvalid_d[win_q] = 1'b1;
               rerr_d          = 1'b0;
               rdata_d         = we_q ? 32'd0 : bus.mem_rdata;
               state_d         = IDLE;
            end
         end

         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         rr_ptr_q <= '0;
         win_q    <= '0;
         we_q     <= 1'b0;
         size_q   <= 2'b00;
         sign_q   <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
         wait_q   <= '0;
         rvalid_q <= '0;
         rerr_q   <= 1'b0;
         rdata_q  <= '0;
      end else begin
         state_q  <= state_d;
         rr_ptr_q <= rr_ptr_d;
         win_q    <= win_d;
         we_q     <= we_d;
         size_q   <= size_d;
         sign_q   <= sign_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         wait_q   <= wait_d;
         rvalid_q <= rvalid_d;
         rerr_q   <= rerr_d;
         rdata_q  <= rdata_d;
      end
   end

   // Grant is combinational from req, so it is masked while reset is held.
   assign bus.gnt       = w_gnt & {N_PORTS{rst_n}};
   assign bus.rvalid    = rvalid_q;
   assign bus.rerr      = rerr_q;
   assign bus.rdata     = rdata_q;
   assign bus.mem_we    = w_mem_we;
   assign bus.mem_size  = size_q;
   assign bus.mem_sign  = sign_q;
   assign bus.mem_addr  = addr_q;
   assign bus.mem_wdata = wdata_q;

endmodule

`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
// ============================================================================
// Module   : tb_dmem_arbiter
// Purpose  : Directed scoreboard bench; instance 0 has WAIT_CYCLES=0,
//            instance 1 has WAIT_CYCLES=3, each with its own byte memory.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_dmem_arbiter;

   localparam int NP = 2;

   typedef struct {
      int          port;
      logic        err;
      logic [31:0] data;
   } exp_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;
   int cyc_n    = 0;
   always @(posedge clk) cyc_n++;

   logic [NP-1:0]    s_req   [2];
   logic [NP-1:0]    s_we    [2];
   logic [2*NP-1:0]  s_size  [2];
   logic [NP-1:0]    s_sign  [2];
   logic [32*NP-1:0] s_addr  [2];
   logic [32*NP-1:0] s_wdata [2];
   logic [31:0]      m_rdata [2];

   logic [NP-1:0] o_gnt      [2];
   logic [NP-1:0] o_rvalid   [2];
   logic          o_rerr     [2];
   logic [31:0]   o_rdata    [2];
   logic          o_mem_we   [2];
   logic [1:0]    o_mem_size [2];
   logic          o_mem_sign [2];
   logic [31:0]   o_mem_addr [2];
   logic [31:0]   o_mem_wdata[2];

   dmem_arbiter_if #(.N_PORTS(NP)) bus_a ();
   dmem_arbiter_if #(.N_PORTS(NP)) bus_b ();

   dmem_arbiter #(.N_PORTS(NP), .WAIT_CYCLES(0)) dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
   dmem_arbiter #(.N_PORTS(NP), .WAIT_CYCLES(3)) dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));

   assign bus_a.req = s_req[0];   assign bus_a.req_we = s_we[0];     assign bus_a.req_size = s_size[0];
   assign bus_a.req_sign = s_sign[0]; assign bus_a.req_addr = s_addr[0]; assign bus_a.req_wdata = s_wdata[0];
   assign bus_a.mem_rdata = m_rdata[0];
   assign bus_b.req = s_req[1];   assign bus_b.req_we = s_we[1];     assign bus_b.req_size = s_size[1];
   assign bus_b.req_sign = s_sign[1]; assign bus_b.req_addr = s_addr[1]; assign bus_b.req_wdata = s_wdata[1];
   assign bus_b.mem_rdata = m_rdata[1];

   assign o_gnt[0] = bus_a.gnt;           assign o_gnt[1] = bus_b.gnt;
   assign o_rvalid[0] = bus_a.rvalid;     assign o_rvalid[1] = bus_b.rvalid;
   assign o_rerr[0] = bus_a.rerr;         assign o_rerr[1] = bus_b.rerr;
   assign o_rdata[0] = bus_a.rdata;       assign o_rdata[1] = bus_b.rdata;
   assign o_mem_we[0] = bus_a.mem_we;     assign o_mem_we[1] = bus_b.mem_we;
   assign o_mem_size[0] = bus_a.mem_size; assign o_mem_size[1] = bus_b.mem_size;
   assign o_mem_sign[0] = bus_a.mem_sign; assign o_mem_sign[1] = bus_b.mem_sign;
   assign o_mem_addr[0] = bus_a.mem_addr; assign o_mem_addr[1] = bus_b.mem_addr;
   assign o_mem_wdata[0] = bus_a.mem_wdata; assign o_mem_wdata[1] = bus_b.mem_wdata;

   // ---------------- memory model (little-endian, low 8 address bits) ----------------
   logic [7:0] mem [2][256];

   function automatic logic [31:0] mem_rd(int k, logic [1:0] sz, logic sg, logic [31:0] ad);
      logic [7:0]  a;
      logic [31:0] r;
      a = ad[7:0];
      case (sz)
         2'b00:   r = {mem[k][a+8'd3], mem[k][a+8'd2], mem[k][a+8'd1], mem[k][a]};
         2'b01:   r = {{16{sg & mem[k][a+8'd1][7]}}, mem[k][a+8'd1], mem[k][a]};
         default: r = {{24{sg & mem[k][a][7]}}, mem[k][a]};
      endcase
      return r;
   endfunction

   task automatic mem_wr(int k, logic [1:0] sz, logic [31:0] ad, logic [31:0] wd);
      logic [7:0] a;
      a = ad[7:0];
      mem[k][a] = wd[7:0];
      if (sz != 2'b10) mem[k][a+8'd1] = wd[15:8];
      if (sz == 2'b00) begin
         mem[k][a+8'd2] = wd[23:16];
         mem[k][a+8'd3] = wd[31:24];
      end
   endtask

   always @(posedge clk)
      for (int k = 0; k < 2; k++)
         if (o_mem_we[k] === 1'b1) mem_wr(k, o_mem_size[k], o_mem_addr[k], o_mem_wdata[k]);

   always @(negedge clk)
      for (int k = 0; k < 2; k++)
         m_rdata[k] = mem_rd(k, o_mem_size[k], o_mem_sign[k], o_mem_addr[k]);

   // ---------------- checking / scoreboard ----------------
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_checks++;
      assert (obs === exp_v)
      else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
      end
   endtask

   exp_t sb0[$];
   exp_t sb1[$];

   function automatic void q_push(int k, exp_t e);
      if (k == 0) sb0.push_back(e); else sb1.push_back(e);
   endfunction
   function automatic int q_size(int k);
      return (k == 0) ? sb0.size() : sb1.size();
   endfunction
   function automatic exp_t q_pop(int k);
      if (k == 0) return sb0.pop_front();
      return sb1.pop_front();
   endfunction
   function automatic int wcyc(int k);
      return (k == 1) ? 3 : 0;
   endfunction

   int we_cnt [2] = '{0, 0};
   int we_cyc [2] = '{0, 0};
   int rv_cyc [2] = '{0, 0};
   int rv_tot [2] = '{0, 0};

   always @(negedge clk) begin
      exp_t e;
      for (int k = 0; k < 2; k++) begin
         if (o_mem_we[k] === 1'b1) begin
            we_cnt[k]++;
            we_cyc[k] = cyc_n;
         end
         if (o_rvalid[k] !== '0) begin
            rv_cyc[k] = cyc_n;
            rv_tot[k]++;
            if (q_size(k) == 0) begin
               chk("unexpected_rvalid", 32'(o_rvalid[k]), 32'd0);
            end else begin
               e = q_pop(k);
               chk("rvalid_port", 32'(o_rvalid[k]), 32'd1 << e.port);
               chk("rerr", 32'(o_rerr[k]), 32'(e.err));
               chk("rdata", o_rdata[k], e.data);
            end
         end
      end
   end

   task automatic wait_empty(int k);
      int cyc = 0;
      while (q_size(k) != 0 && cyc < 50) begin
         @(posedge clk); #3;
         cyc++;
      end
      chk("resp_timeout", 32'(q_size(k)), 32'd0);
   endtask

   // Single transaction on one port; also checks latency and write-strobe timing.
   task automatic issue(int k, int p, bit we, bit [1:0] sz, bit sg, bit [31:0] ad,
                        bit [31:0] wd, bit e_err, bit [31:0] e_data);
      int cyc = 0;
      int g_cyc;
      int wc0;
      @(posedge clk); #2;
      s_we[k][p] = we;
      s_size[k][2*p +: 2] = sz;
      s_sign[k][p] = sg;
      s_addr[k][32*p +: 32] = ad;
      s_wdata[k][32*p +: 32] = wd;
      s_req[k][p] = 1'b1;
      #1;
      while (o_gnt[k] !== (NP'(1) << p) && cyc < 20) begin
         @(posedge clk); #2;
         cyc++;
      end
      chk("gnt", 32'(o_gnt[k]), 32'd1 << p);
      g_cyc = cyc_n;
      wc0   = we_cnt[k];
      q_push(k, '{p, e_err, e_data});
      @(posedge clk); #2;
      s_req[k][p] = 1'b0;
      wait_empty(k);
      chk("latency", 32'(rv_cyc[k] - g_cyc), e_err ? 32'd1 : 32'(2 + wcyc(k)));
      chk("we_count", 32'(we_cnt[k] - wc0), (we && !e_err) ? 32'd1 : 32'd0);
      if (we && !e_err) chk("we_cycle", 32'(we_cyc[k] - g_cyc), 32'(1 + wcyc(k)));
   endtask

   // Word loads held on the ports in mask; expects winners 0,1,0,1.. (or all 0).
   task automatic stream(int k, bit [1:0] mask, int n, bit [31:0] a0, bit [31:0] a1,
                         bit [31:0] d0, bit [31:0] d1);
      int cyc;
      int prev = 0;
      int p;
      @(posedge clk); #2;
      s_we[k] = '0; s_size[k] = '0; s_sign[k] = '0;
      s_addr[k] = {a1, a0};
      s_req[k] = mask;
      #1;
      for (int g = 0; g < n; g++) begin
         p = (mask == 2'b11) ? g % 2 : 0;
         cyc = 0;
         while (o_gnt[k] === '0 && cyc < 20) begin
            @(posedge clk); #2;
            cyc++;
         end
         chk("rr_grant", 32'(o_gnt[k]), 32'd1 << p);
         if (g > 0) chk("grant_spacing", 32'(cyc_n - prev), 32'(2 + wcyc(k)));
         prev = cyc_n;
         q_push(k, '{p, 1'b0, (p == 0) ? d0 : d1});
         @(posedge clk); #2;
      end
      s_req[k] = '0;
      wait_empty(k);
   endtask

   // Store on instance 1 cut short by reset n_adv cycles after acceptance.
   task automatic abort_store(int n_adv);
      int cyc = 0;
      int rv0;
      @(posedge clk); #2;
      s_we[1] = 2'b01; s_size[1] = '0; s_sign[1] = '0;
      s_addr[1][31:0] = 32'h0001_0010;
      s_wdata[1][31:0] = 32'hA5A5_A5A5;
      s_req[1] = 2'b01;
      #1;
      while (o_gnt[1] !== 2'b01 && cyc < 20) begin
         @(posedge clk); #2;
         cyc++;
      end
      chk("abort_gnt", 32'(o_gnt[1]), 32'd1);
      @(posedge clk); #2;
      s_req[1] = '0;
      repeat (n_adv) begin @(posedge clk); #2; end
      chk("abort_we_before", 32'(o_mem_we[1]), 32'(n_adv == 3));
      rv0 = rv_tot[1];
      rst_n = 1'b0;
      #1;
      chk("abort_we_drop", 32'(o_mem_we[1]), 32'd0);
      chk("abort_rvalid", 32'(o_rvalid[1]), 32'd0);
      s_req[1] = 2'b11;
      #1;
      chk("gnt_in_reset", 32'(o_gnt[1]), 32'd0);
      s_req[1] = '0;
      @(posedge clk); @(posedge clk); #2;
      rst_n = 1'b1;
      repeat (8) @(posedge clk);
      #2;
      chk("abort_no_rvalid", 32'(rv_tot[1] - rv0), 32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int k = 0; k < 2; k++) begin
         for (int i = 0; i < 256; i++) mem[k][i] = 8'(i);
         s_req[k] = '0; s_we[k] = '0; s_size[k] = '0;
         s_sign[k] = '0; s_addr[k] = '0; s_wdata[k] = '0;
      end

      repeat (3) @(posedge clk);
      #2;
      for (int k = 0; k < 2; k++) begin
         chk("rst_gnt", 32'(o_gnt[k]), 32'd0);
         chk("rst_rvalid", 32'(o_rvalid[k]), 32'd0);
         chk("rst_rerr", 32'(o_rerr[k]), 32'd0);
         chk("rst_rdata", o_rdata[k], 32'd0);
         chk("rst_mem_we", 32'(o_mem_we[k]), 32'd0);
         chk("rst_mem_size", 32'(o_mem_size[k]), 32'd0);
         chk("rst_mem_sign", 32'(o_mem_sign[k]), 32'd0);
         chk("rst_mem_addr", o_mem_addr[k], 32'd0);
         chk("rst_mem_wdata", o_mem_wdata[k], 32'd0);
      end
      @(negedge clk);
      rst_n = 1'b1;

      // Both ports contend from reset: grants 0,1,0,1.
      stream(0, 2'b11, 4, 32'h0001_0000, 32'h0001_0004, 32'h0302_0100, 32'h0706_0504);

      // Word store then load back, WAIT_CYCLES=0.
      issue(0, 0, 1'b1, 2'b00, 1'b0, 32'h0001_0000, 32'hDEAD_BEEF, 1'b0, 32'h0);
      issue(0, 0, 1'b0, 2'b00, 1'b0, 32'h0001_0000, 32'h0,         1'b0, 32'hDEAD_BEEF);

      // Rejected accesses: misaligned half, invalid size.
      issue(0, 1, 1'b0, 2'b01, 1'b0, 32'h0001_0001, 32'h0,         1'b1, 32'h0);
      issue(0, 1, 1'b0, 2'b11, 1'b0, 32'h0001_0000, 32'h0,         1'b1, 32'h0);
      issue(0, 1, 1'b1, 2'b00, 1'b0, 32'h0001_0002, 32'h1234_5678, 1'b1, 32'h0);

      // Half loads with and without sign extension.
      issue(0, 0, 1'b0, 2'b01, 1'b1, 32'h0001_0002, 32'h0,         1'b0, 32'hFFFF_DEAD);
      issue(0, 1, 1'b0, 2'b01, 1'b0, 32'h0001_0000, 32'h0,         1'b0, 32'h0000_BEEF);

      // WAIT_CYCLES=3: byte store, signed and unsigned byte loads.
      issue(1, 0, 1'b1, 2'b10, 1'b0, 32'h0001_0003, 32'h0000_0080, 1'b0, 32'h0);
      issue(1, 0, 1'b0, 2'b10, 1'b1, 32'h0001_0003, 32'h0,         1'b0, 32'hFFFF_FF80);
      issue(1, 0, 1'b0, 2'b10, 1'b0, 32'h0001_0003, 32'h0,         1'b0, 32'h0000_0080);

      // Single requester held: granted every IDLE cycle.
      stream(1, 2'b01, 3, 32'h0001_0000, 32'h0001_0004, 32'h8002_0100, 32'h0706_0504);

      // Reset during ACCESS with counter 2, then with the write strobe high.
      abort_store(1);
      abort_store(3);

      // Pointer back at 0 after reset; aborted store left memory untouched.
      stream(1, 2'b11, 2, 32'h0001_0010, 32'h0001_0004, 32'h1312_1110, 32'h0706_0504);

      repeat (4) @(posedge clk);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

`default_nettype wire
